// File: rtl/rf_rob_map.sv
// Register-to-ROB-tag map: one {valid, tag} per architectural register, combinational reads, registered pending count.
// Optional macro RF_ROB_COMMIT_BYPASS_EN: a same-cycle matching commit hides the entry's valid on the read ports.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module rf_rob_map #(
    parameter int NUM_REGS        = 32,
    parameter int REG_WIDTH       = 5,
    parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REG_WIDTH-1:0]       rs1,
    input  logic [REG_WIDTH-1:0]       rs2,
    output logic [ROB_ENTRY_WIDTH-1:0] rs1_rob_entry,
    output logic                       rs1_rob_entry_valid,
    output logic [ROB_ENTRY_WIDTH-1:0] rs2_rob_entry,
    output logic                       rs2_rob_entry_valid,
    input  logic                       alloc_valid,
    input  logic [REG_WIDTH-1:0]       alloc_rd,
    input  logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_id,
    input  logic                       commit_valid,
    input  logic [REG_WIDTH-1:0]       commit_rd,
    input  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
    input  logic                       flush,
    output logic [REG_WIDTH:0]         pending_count
);

    logic [NUM_REGS-1:0]        valid;
    logic [ROB_ENTRY_WIDTH-1:0] tag [NUM_REGS];

    logic alloc_wr;
    logic commit_hit;
    logic commit_clr;
    logic cnt_inc;
    logic cnt_dec;

    assign alloc_wr   = alloc_valid && (alloc_rd != '0);
    assign commit_hit = commit_valid && valid[commit_rd] && (tag[commit_rd] == commit_rob_id);
    // A same-register allocation supersedes the retiring writer, so the entry stays live.
    assign commit_clr = commit_hit && !(alloc_wr && (alloc_rd == commit_rd));
    assign cnt_inc    = alloc_wr && !valid[alloc_rd];
    assign cnt_dec    = commit_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid         <= '0;
            pending_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag[i] <= '0;
            end
        end else if (flush) begin
            valid         <= '0;
            pending_count <= '0;
        end else begin
            if (commit_clr) begin
                valid[commit_rd] <= 1'b0;
            end
            if (alloc_wr) begin
                valid[alloc_rd] <= 1'b1;
                tag[alloc_rd]   <= alloc_rob_id;
            end
            pending_count <= pending_count + {{REG_WIDTH{1'b0}}, cnt_inc}
                                           - {{REG_WIDTH{1'b0}}, cnt_dec};
        end
    end

    logic rs1_kill;
    logic rs2_kill;

`ifdef RF_ROB_COMMIT_BYPASS_EN
    assign rs1_kill = commit_valid && (commit_rd == rs1) && (tag[rs1] == commit_rob_id);
    assign rs2_kill = commit_valid && (commit_rd == rs2) && (tag[rs2] == commit_rob_id);
`else
    assign rs1_kill = 1'b0;
    assign rs2_kill = 1'b0;
`endif

    // Register 0 is hardwired: never pending, tag reads as zero.
    always_comb begin
        rs1_rob_entry       = '0;
        rs1_rob_entry_valid = 1'b0;
        rs2_rob_entry       = '0;
        rs2_rob_entry_valid = 1'b0;
        if (rs1 != '0) begin
            rs1_rob_entry       = tag[rs1];
            rs1_rob_entry_valid = valid[rs1] && !rs1_kill;
        end
        if (rs2 != '0) begin
            rs2_rob_entry       = tag[rs2];
            rs2_rob_entry_valid = valid[rs2] && !rs2_kill;
        end
    end

endmodule
